// File: rtl/vec_dispatch_queue_pkg.sv
// Shared constants for the vector dispatch queue: default widths and fence FSM encodings.
package vec_dispatch_queue_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int XLEN_DEF    = 32;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_DRAIN = 2'd1,
        F_DONE  = 2'd2
    } fence_state_e;

    // Drain is complete once nothing is buffered and the coprocessor has nothing in flight.
    function automatic logic fence_drained(input logic queue_empty, input logic copro_idle);
        return queue_empty & copro_idle;
    endfunction

endpackage

// File: rtl/vec_dispatch_queue_sync_fifo_core.sv
// Circular-buffer storage with registered pointers, occupancy count and full/empty flags.
module sync_fifo_core
    import vec_dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = INSTR_W_DEF + XLEN_DEF
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_r;

    // Next occupancy from the qualified push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and flags; clear wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else if (clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

    assign rd_data = empty_r ? {W{1'b0}} : mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/vec_dispatch_queue.sv
// Buffered core-to-coprocessor instruction route with flush and fence (drain-and-wait) support.
module vec_dispatch_queue
    import vec_dispatch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [INSTR_W-1:0]     issue_instr,
    input  logic [XLEN-1:0]        issue_xdata,
    output logic                   disp_valid,
    input  logic                   disp_ready,
    output logic [INSTR_W-1:0]     disp_instr,
    output logic [XLEN-1:0]        disp_xdata,
    input  logic                   flush,
    input  logic                   fence_req,
    input  logic                   v_idle,
    output logic                   fence_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int W = INSTR_W + XLEN;

    fence_state_e state_r;
    logic         fence_done_r;
    logic         push_s;
    logic         pop_s;
    logic [W-1:0] head_s;

    assign issue_ready = ~full & (state_r == F_IDLE) & ~flush;
    assign disp_valid  = ~empty;
    assign push_s      = issue_valid & issue_ready;
    assign pop_s       = disp_valid & disp_ready;

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push    (push_s),
        .pop     (pop_s),
        .clear   (flush),
        .wr_data ({issue_instr, issue_xdata}),
        .rd_data (head_s),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign disp_instr = head_s[W-1:XLEN];
    assign disp_xdata = head_s[XLEN-1:0];

    // Fence FSM; flush deliberately leaves the fence state alone.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= F_IDLE;
            fence_done_r <= 1'b0;
        end else begin
            case (state_r)
                F_IDLE: begin
                    fence_done_r <= 1'b0;
                    if (fence_req) begin
                        state_r <= F_DRAIN;
                    end else begin
                        state_r <= F_IDLE;
                    end
                end
                F_DRAIN: begin
                    if (fence_drained(empty, v_idle)) begin
                        state_r      <= F_DONE;
                        fence_done_r <= 1'b1;
                    end else begin
                        state_r      <= F_DRAIN;
                        fence_done_r <= 1'b0;
                    end
                end
                F_DONE: begin
                    state_r      <= F_IDLE;
                    fence_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= F_IDLE;
                    fence_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign fence_done = fence_done_r;

endmodule

// File: tb/tb_vec_dispatch_queue.sv
// Directed self-checking bench for vec_dispatch_queue (DEPTH=4).
module tb_vec_dispatch_queue;

    logic        clk = 1'b0;
    logic        nrst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [31:0] issue_xdata;
    logic        disp_valid;
    logic        disp_ready;
    logic [31:0] disp_instr;
    logic [31:0] disp_xdata;
    logic        flush;
    logic        fence_req;
    logic        v_idle;
    logic        fence_done;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int checks_total  = 0;
    int checks_passed = 0;

    vec_dispatch_queue #(.DEPTH(4), .INSTR_W(32), .XLEN(32)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_instr (issue_instr),
        .issue_xdata (issue_xdata),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_instr  (disp_instr),
        .disp_xdata  (disp_xdata),
        .flush       (flush),
        .fence_req   (fence_req),
        .v_idle      (v_idle),
        .fence_done  (fence_done),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            issue_valid = 1'b1;
            issue_instr = base + 32'(i);
            issue_xdata = 32'h0;
            tick();
        end
        issue_valid = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; issue_valid = 1'b0; issue_instr = 32'h0; issue_xdata = 32'h0;
        disp_ready = 1'b0; flush = 1'b0; fence_req = 1'b0; v_idle = 1'b0;
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_disp_valid", 64'(disp_valid), 64'd0);
        check("rst_fence_done", 64'(fence_done), 64'd0);
        check("rst_disp_instr", 64'(disp_instr), 64'd0);
        nrst = 1'b1;
        tick();

        // single push, one-cycle latency
        issue_valid = 1'b1; issue_instr = 32'h0000_0057; issue_xdata = 32'h11;
        check("first_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0;
        check("first_valid", 64'(disp_valid), 64'd1);
        check("first_instr", 64'(disp_instr), 64'h57);
        check("first_xdata", 64'(disp_xdata), 64'h11);
        check("first_count", 64'(count), 64'd1);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check("first_drained", 64'(empty), 64'd1);

        // fill to full, extra issue ignored
        push_n(4, 32'h100);
        check("full_flag", 64'(full), 64'd1);
        check("full_ready", 64'(issue_ready), 64'd0);
        check("full_count", 64'(count), 64'd4);
        issue_valid = 1'b1; issue_instr = 32'h1FF;
        tick();
        issue_valid = 1'b0;
        check("full_ignored_count", 64'(count), 64'd4);
        check("full_head", 64'(disp_instr), 64'h100);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check("after_pop_ready", 64'(issue_ready), 64'd1);
        check("after_pop_count", 64'(count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            check("full_order", 64'(disp_instr), 64'(32'h100 + 32'(i)));
            disp_ready = 1'b1;
            tick();
        end
        disp_ready = 1'b0;
        check("full_drained", 64'(empty), 64'd1);

        // streaming push+pop, pointers wrap twice
        issue_valid = 1'b1; disp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue_instr = 32'(i);
            tick();
            check("stream_instr", 64'(disp_instr), 64'(i));
            check("stream_count", 64'(count), 64'd1);
        end
        issue_valid = 1'b0;
        tick();
        disp_ready = 1'b0;
        check("stream_drained", 64'(empty), 64'd1);

        // flush discards stored entries and the same-cycle issue
        push_n(3, 32'h300);
        check("pre_flush_count", 64'(count), 64'd3);
        issue_valid = 1'b1; issue_instr = 32'h3AA; flush = 1'b1;
        #1;
        check("flush_ready", 64'(issue_ready), 64'd0);
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_valid", 64'(disp_valid), 64'd0);
        tick();
        check("flush_not_stored", 64'(empty), 64'd1);

        // fence with pending entries and busy coprocessor
        push_n(2, 32'h500);
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        check("drain_ready", 64'(issue_ready), 64'd0);
        issue_valid = 1'b1; issue_instr = 32'h5FF;
        disp_ready = 1'b1;
        tick();
        tick();
        disp_ready = 1'b0;
        check("drain_count", 64'(count), 64'd0);
        check("drain_no_done", 64'(fence_done), 64'd0);
        v_idle = 1'b1;
        tick();
        check("fence_done_pulse", 64'(fence_done), 64'd1);
        check("done_ready", 64'(issue_ready), 64'd0);
        tick();
        check("fence_done_clear", 64'(fence_done), 64'd0);
        check("fence_ready_back", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0;
        check("post_fence_count", 64'(count), 64'd1);
        check("post_fence_instr", 64'(disp_instr), 64'h5FF);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;

        // fence on an already-idle queue still takes two cycles
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        check("idle_fence_c1", 64'(fence_done), 64'd0);
        tick();
        check("idle_fence_c2", 64'(fence_done), 64'd1);
        tick();
        check("idle_fence_c3", 64'(fence_done), 64'd0);

        // asynchronous reset in the middle of a fence
        v_idle = 1'b0;
        push_n(3, 32'h600);
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        check("mid_fence_ready", 64'(issue_ready), 64'd0);
        #2;
        nrst = 1'b0;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_valid", 64'(disp_valid), 64'd0);
        tick();
        nrst = 1'b1;
        v_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_fence_done", 64'(fence_done), 64'd0);
        end
        check("post_rst_ready", 64'(issue_ready), 64'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
